// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   in_valid/in_ready : operand transfer handshake (a, b, op)
//   out_valid/out_ready : result transfer handshake (result, flags)
//   flags = {err, v, c, n, z}
// master modport drives operands and consumes results; slave is the ALU side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshakes.
//   Single-cycle ops (add/sub/logic/shift/rotate) register their result on
//   the accepting edge. With macro ALU_PIPE_MUL_EN defined, opcode 11 runs an
//   iterative shift-add multiply (IDLE->BUSY for WIDTH cycles); otherwise
//   opcode 11 is treated as reserved and no multiplier/BUSY state exists.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_pipe_if.slave (in_valid/in_ready/a/b/op, out_valid/out_ready/
//           result/flags with flags = {err, v, c, n, z})
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);
  localparam int unsigned SH = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;

  logic             r_run;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_flags;

  logic             w_idle;
  logic             w_is_mul;
  logic             w_in_ready;
  logic             w_accept;
  logic [SH-1:0]    w_amt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sra;
  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  // in_ready stays low during reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign w_in_ready = r_run & w_idle & (~r_out_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Extra bit on each shift captures the last bit shifted out (0 for amount 0)
  assign w_amt = bus.b[SH-1:0];
  assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_shl = {1'b0, bus.a} << w_amt;
  assign w_shr = {bus.a, 1'b0} >> w_amt;
  assign w_sra = $unsigned($signed({bus.a, 1'b0}) >>> w_amt);
  assign w_rol = {bus.a, bus.a} << w_amt;
  assign w_ror = {bus.a, bus.a} >> w_amt;

  // Single-cycle datapath; reserved opcodes fall to the default
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (w_add[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_XOR: w_res = bus.a ^ bus.b;
      OP_NOT: w_res = ~bus.a;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      OP_ROL: begin
        w_res = w_rol[2*WIDTH-1:WIDTH];
        w_c   = (w_amt != '0) & w_rol[WIDTH];
      end
      OP_ROR: begin
        w_res = w_ror[WIDTH-1:0];
        w_c   = (w_amt != '0) & w_ror[WIDTH-1];
      end
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [SH-1:0]    r_cnt;
  logic [WIDTH:0]   w_msum;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_idle   = (r_state == S_IDLE);
  assign w_is_mul = (bus.op == OP_MUL);

  // One shift-add step: add multiplicand to the high half when the current
  // multiplier LSB is set, then shift {hi, lo} right by one
  assign w_msum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_hi   = w_msum[WIDTH:1];
  assign w_mul_lo   = {w_msum[0], r_lo[WIDTH-1:1]};
  assign w_mul_done = (r_state == S_BUSY) & (r_cnt == SH'(WIDTH - 1));

  // Multiplier sequencer: WIDTH iterations, the last one also loads the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= S_BUSY;
            r_mcand <= bus.a;
            r_hi    <= '0;
            r_lo    <= bus.b;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt + SH'(1);
          if (w_mul_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_idle   = 1'b1;
  assign w_is_mul = 1'b0;
`endif

  // Output register: load on single-cycle accept or multiply completion,
  // otherwise hold until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_flags     <= {w_err, w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
    end
`ifdef ALU_PIPE_MUL_EN
    else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_lo;
      r_flags     <= {1'b0, 1'b0, (w_mul_hi != '0), w_mul_lo[WIDTH-1], (w_mul_lo == '0)};
    end
`endif
    else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=16).
// flags = {err, v, c, n, z}. The multiply and reset-during-multiply steps
// follow the ALU_PIPE_MUL_EN build; otherwise opcode 11 is checked as reserved.
module tb_alu_pipe;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic [4:0] f);
    chk({tag, ".valid"},  32'(bus.out_valid), 32'd1);
    chk({tag, ".result"}, 32'(bus.result),    32'(r));
    chk({tag, ".flags"},  32'(bus.flags),     32'(f));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},    32'(bus.out_valid), 32'd0);
    chk({tag, ".result"},   32'(bus.result),    32'd0);
    chk({tag, ".flags"},    32'(bus.flags),     32'd0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready),  32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 16'h0000);

    // Reset state
    #2;
    chk_zero("rst_async");
    step();
    step();
    chk_zero("rst_held");
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("first_edge_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back single-cycle ops, one result per cycle
    drive(1'b1, 4'd0, 16'hFFFF, 16'h0001); step(); chk_out("add_wrap",  16'h0000, 5'b00101);
    drive(1'b1, 4'd1, 16'h8000, 16'h0001); step(); chk_out("sub_ovf",   16'h7FFF, 5'b01000);
    drive(1'b1, 4'd1, 16'h0001, 16'h0002); step(); chk_out("sub_borrow",16'hFFFF, 5'b00110);
    drive(1'b1, 4'd8, 16'h8000, 16'h0004); step(); chk_out("sra",       16'hF800, 5'b00010);
    drive(1'b1, 4'd6, 16'h8001, 16'h0001); step(); chk_out("shl",       16'h0002, 5'b00100);
    drive(1'b1, 4'd7, 16'h0003, 16'h0001); step(); chk_out("shr",       16'h0001, 5'b00100);
    drive(1'b1, 4'd7, 16'h1234, 16'h0000); step(); chk_out("shr_zero",  16'h1234, 5'b00000);
    drive(1'b1, 4'd9, 16'h8000, 16'h0001); step(); chk_out("rol",       16'h0001, 5'b00100);
    drive(1'b1, 4'd10,16'h0001, 16'h0001); step(); chk_out("ror",       16'h8000, 5'b00110);
    drive(1'b1, 4'd10,16'h00F0, 16'h0004); step(); chk_out("ror4",      16'h000F, 5'b00000);
    drive(1'b1, 4'd2, 16'h1234, 16'h00FF); step(); chk_out("and",       16'h0034, 5'b00000);
    drive(1'b1, 4'd3, 16'h1200, 16'h0034); step(); chk_out("or",        16'h1234, 5'b00000);
    drive(1'b1, 4'd4, 16'hF0F0, 16'hFFFF); step(); chk_out("xor",       16'h0F0F, 5'b00000);
    drive(1'b1, 4'd5, 16'hFFFF, 16'h1234); step(); chk_out("not",       16'h0000, 5'b00001);
    drive(1'b1, 4'd0, 16'h7FFF, 16'h0001); step(); chk_out("add_ovf",   16'h8000, 5'b01010);
    drive(1'b1, 4'd13,16'h1234, 16'h5678); step(); chk_out("reserved13",16'h0000, 5'b10001);
`ifndef ALU_PIPE_MUL_EN
    drive(1'b1, 4'd11,16'h0003, 16'h0004); step(); chk_out("mul_absent",16'h0000, 5'b10001);
`endif
    drive(1'b0, 4'd0, 16'h0000, 16'h0000); step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: three queued adds, held result, then ordered drain
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 16'h0001, 16'h0001); step(); chk_out("bp_first", 16'h0002, 5'b00000);
    drive(1'b1, 4'd0, 16'h0002, 16'h0002);
    chk("bp_ready0", 32'(bus.in_ready), 32'd0);
    step(); chk_out("bp_hold1", 16'h0002, 5'b00000);
    step(); chk_out("bp_hold2", 16'h0002, 5'b00000);
    chk("bp_ready1", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step(); chk_out("bp_second", 16'h0004, 5'b00000);
    drive(1'b1, 4'd0, 16'h0003, 16'h0003);
    step(); chk_out("bp_third", 16'h0006, 5'b00000);
    drive(1'b0, 4'd0, 16'h0000, 16'h0000);
    step(); chk("bp_empty", 32'(bus.out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
    // Multiply: in_ready low for WIDTH cycles, result in cycle WIDTH+1
    drive(1'b1, 4'd11, 16'h0100, 16'h0101);
    step();
    drive(1'b1, 4'd0, 16'h0005, 16'h0006);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mul_busy_ready[%0d]", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("mul_busy_valid[%0d]", i), 32'(bus.out_valid), 32'd0);
      if (i < 15) step();
    end
    step(); chk_out("mul_result", 16'h0100, 5'b00100);
    chk("mul_done_ready", 32'(bus.in_ready), 32'd1);
    step(); chk_out("mul_then_add", 16'h000B, 5'b00000);
    drive(1'b1, 4'd11, 16'hFFFF, 16'hFFFF);
    step();
    drive(1'b0, 4'd0, 16'h0000, 16'h0000);
    for (int i = 0; i < 16; i++) step();
    chk_out("mul_max", 16'h0001, 5'b00100);
    step();

    // Reset during multiply: aborts with no result
    drive(1'b1, 4'd11, 16'h0003, 16'h0005);
    step();
    drive(1'b0, 4'd0, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_mul");
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_mul_release_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("rst_mul_first_edge_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 20; i++) step();
    chk("rst_mul_no_result", 32'(bus.out_valid), 32'd0);
    chk("rst_mul_result_zero", 32'(bus.result), 32'd0);
`else
    // Reset with a pending result clears the output stage
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 16'h0001, 16'h0001);
    step(); chk_out("rst_pending", 16'h0002, 5'b00000);
    drive(1'b0, 4'd0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_pending_clear");
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_pend_release_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("rst_pend_first_edge_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pend_no_result", 32'(bus.out_valid), 32'd0);
`endif

    drive(1'b1, 4'd1, 16'h0005, 16'h0003);
    step(); chk_out("post_rst_sub", 16'h0002, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
